// File: rtl/sdram_rdbuf_if.sv
// sdram_rdbuf_if - bus bundle between the read-burst buffer, the SDRAM
// controller (burst request / read strobe / data) and the vector sender
// (pop / head word / status).
//   slave  : the buffer itself
//   master : whoever drives en/flush/rdbstdrdy/dq/vec_rd (controller + sender)
interface sdram_rdbuf_if #(
  parameter int DW = 32,
  parameter int AW = 11
);
  logic          en;
  logic          flush;
  logic          rdbstdrdy;
  logic [DW-1:0] dq;
  logic          burst_req;
  logic          vec_rd;
  logic [DW-1:0] vec_data;
  logic          vec_vld;
  logic [AW:0]   level;
  logic          ovf;
  logic [15:0]   ovf_cnt;

  modport slave (
    input  en, flush, rdbstdrdy, dq, vec_rd,
    output burst_req, vec_data, vec_vld, level, ovf, ovf_cnt
  );

  modport master (
    output en, flush, rdbstdrdy, dq, vec_rd,
    input  burst_req, vec_data, vec_vld, level, ovf, ovf_cnt
  );
endinterface

// File: rtl/sdram_rdbuf.sv
// sdram_rdbuf - read-burst capture buffer behind the SDRAM controller.
// Captures DW-bit words while rdbstdrdy is high, stores them in a 2^AW deep
// circular buffer and presents them one at a time (registered head word) to
// the vector sender. Requests a page burst only when a whole BURST_LEN page
// fits.
// Ports:
//   clk    SDRAM clock, rising edge
//   reset  asynchronous, active-high
//   bus    sdram_rdbuf_if.slave: en, flush, rdbstdrdy, dq, vec_rd in;
//          burst_req, vec_data, vec_vld, level, ovf, ovf_cnt out
// Build option: define SDRAM_RDBUF_OVFCNT_EN to implement the saturating
// dropped-word counter ovf_cnt; otherwise ovf_cnt reads 0.
package sdram_rdbuf_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CAPTURE} state_e;
endpackage

module sdram_rdbuf
  import sdram_rdbuf_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 11,
  parameter int BURST_LEN = 1024
) (
  input logic         clk,
  input logic         reset,
  sdram_rdbuf_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int WCW   = $clog2(BURST_LEN + 1);
  localparam logic [AW:0] FULL_LVL  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] START_MAX = FULL_LVL - (AW+1)'(BURST_LEN);

  logic [DW-1:0]  mem [DEPTH];
  logic [AW:0]    wptr, rptr, level, rptr_inc;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  vec_data_q;
  logic           vec_vld_q, vld_n, ovf_q, burst_req_q;
  logic           full, push, pop, wr_ok, drop;
  logic [WCW-1:0] wcnt;
  state_e         state;

  assign level    = wptr - rptr;
  assign full     = (level == FULL_LVL);
  assign pop      = bus.vec_rd && vec_vld_q;
  assign push     = bus.rdbstdrdy && bus.en && (state != IDLE);
  // A pop in the same edge frees the slot, so a push into a full buffer is kept.
  assign wr_ok    = push && (!full || pop);
  assign drop     = push && !wr_ok;
  assign rptr_inc = rptr + 1'b1;
  // Prefetch looks one word ahead when the head is being consumed.
  assign rd_addr  = pop ? rptr_inc[AW-1:0] : rptr[AW-1:0];
  // A word written this edge is not visible until the next one.
  assign vld_n    = pop ? (level >= (AW+1)'(2)) : (level != '0);

  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem[wptr[AW-1:0]] <= bus.dq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0; rptr <= '0; vec_data_q <= '0; vec_vld_q <= 1'b0; ovf_q <= 1'b0;
    end else if (bus.flush) begin
      wptr <= '0; rptr <= '0; vec_data_q <= '0; vec_vld_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr_inc;
      if (drop)  ovf_q <= 1'b1;
      vec_vld_q <= vld_n;
      if (vld_n) vec_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE; burst_req_q <= 1'b0; wcnt <= '0;
    end else if (bus.flush) begin
      state <= IDLE; burst_req_q <= 1'b0; wcnt <= '0;
    end else if (!bus.en) begin
      state <= IDLE; burst_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (level <= START_MAX) begin
          state <= REQ; burst_req_q <= 1'b1;
        end
        REQ: if (bus.rdbstdrdy) begin
          wcnt <= WCW'(1); burst_req_q <= 1'b0;
          state <= (BURST_LEN == 1) ? IDLE : CAPTURE;
        end
        CAPTURE: if (bus.rdbstdrdy) begin
          // Dropped words still count: the controller sends the whole page.
          wcnt <= wcnt + 1'b1;
          if (wcnt == WCW'(BURST_LEN - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_RDBUF_OVFCNT_EN
  logic [15:0] ovf_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            ovf_cnt_q <= '0;
    else if (bus.flush)                   ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end
  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = '0;
`endif

  assign bus.burst_req = burst_req_q;
  assign bus.vec_data  = vec_data_q;
  assign bus.vec_vld   = vec_vld_q;
  assign bus.level     = level;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sdram_rdbuf.sv
// tb_sdram_rdbuf - directed bench with a data scoreboard. Stimulus pushes
// expected words into exp_q; the negedge monitor pops and compares on every
// accepted pop. Status outputs are checked directly against constants.
module tb_sdram_rdbuf;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BL = 1024;
`ifdef SDRAM_RDBUF_OVFCNT_EN
  localparam int OVF3 = 3;
`else
  localparam int OVF3 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_rdbuf_if #(.DW(DW), .AW(AW)) bus ();
  sdram_rdbuf #(.DW(DW), .AW(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: the word on vec_data is consumed at the next edge.
  always @(negedge clk) begin
    if (!reset && bus.vec_rd === 1'b1 && bus.vec_vld === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got %0h with no expected word", bus.vec_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.vec_data !== mon_exp) begin
          n_err++;
          $display("FAIL sb_data: got %0h expected %0h", bus.vec_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (bus.burst_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(name, 32'(bus.burst_req), 32'd1);
  endtask

  task automatic send(input int n, input logic [31:0] base, input bit keep);
    for (int i = 0; i < n; i++) begin
      bus.rdbstdrdy = 1'b1;
      bus.dq = base + 32'(i);
      if (keep) exp_q.push_back(base + 32'(i));
      tick();
    end
    bus.rdbstdrdy = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.vec_rd = 1'b1;
    repeat (n) tick();
    bus.vec_rd = 1'b0;
  endtask

  task automatic drain_all(input string name, input int limit);
    int k = 0;
    bus.vec_rd = 1'b1;
    while ((bus.level != '0 || bus.vec_vld) && k < limit) begin
      tick();
      k++;
    end
    bus.vec_rd = 1'b0;
    chk(name, 32'(bus.level), 32'd0);
    chk({name, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_burst_req"}, 32'(bus.burst_req), 32'd0);
    chk({tag, "_vec_vld"},   32'(bus.vec_vld),   32'd0);
    chk({tag, "_vec_data"},  bus.vec_data,       32'd0);
    chk({tag, "_level"},     32'(bus.level),     32'd0);
    chk({tag, "_ovf"},       32'(bus.ovf),       32'd0);
    chk({tag, "_ovf_cnt"},   32'(bus.ovf_cnt),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.flush = 1'b0; bus.rdbstdrdy = 1'b0;
    bus.dq = '0;   bus.vec_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b0;
    tick();

    // Two full page bursts fill the 2048-word buffer; latency of first word.
    bus.en = 1'b1;
    wait_req("req1");
    bus.rdbstdrdy = 1'b1; bus.dq = 32'd0; exp_q.push_back(32'd0);
    tick();
    chk("req_fall",  32'(bus.burst_req), 32'd0);
    chk("lvl1",      32'(bus.level),     32'd1);
    chk("vld_lag",   32'(bus.vec_vld),   32'd0);
    bus.dq = 32'd1; exp_q.push_back(32'd1);
    tick();
    chk("vld_first", 32'(bus.vec_vld),   32'd1);
    chk("data_first", bus.vec_data,      32'd0);
    chk("lvl2",      32'(bus.level),     32'd2);
    send(BL - 2, 32'd2, 1'b1);
    chk("lvl1024",   32'(bus.level),     32'd1024);
    wait_req("req2");
    send(BL, 32'(BL), 1'b1);
    chk("lvl2048",   32'(bus.level),     32'd2048);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_req", 32'(bus.burst_req), 32'd0);
    end

    // Directed override: hold the FSM in REQ while full.
    force dut.state = sdram_rdbuf_pkg::REQ;
    bus.vec_rd = 1'b1;
    send(4, 32'd2048, 1'b1);           // push+pop at full, wraps into slot 0
    bus.vec_rd = 1'b0;
    chk("pp_level",  32'(bus.level),     32'd2048);
    chk("pp_ovf",    32'(bus.ovf),       32'd0);
    send(3, 32'hDEAD0000, 1'b0);       // dropped
    chk("ovf_set",   32'(bus.ovf),       32'd1);
    chk("ovf_cnt3",  32'(bus.ovf_cnt),   32'(OVF3));
    chk("ovf_level", 32'(bus.level),     32'd2048);
    bus.en = 1'b0;
    tick();
    release dut.state;
    tick();
    chk("abort_req", 32'(bus.burst_req), 32'd0);
    drain_all("drain_wrap", 2100);     // 4..2051, wrapped words included
    chk("ovf_sticky", 32'(bus.ovf),      32'd1);

    // Abort a burst at 700 words, then flush with ovf set.
    bus.en = 1'b1;
    wait_req("req3");
    send(700, 32'h3000, 1'b0);
    bus.en = 1'b0;
    tick();
    chk("lvl700",    32'(bus.level),     32'd700);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_level",  32'(bus.level),     32'd0);
    chk("fl_vld",    32'(bus.vec_vld),   32'd0);
    chk("fl_ovf",    32'(bus.ovf),       32'd0);
    chk("fl_ovfcnt", 32'(bus.ovf_cnt),   32'd0);

    // en dropped at wcnt=500.
    bus.en = 1'b1;
    wait_req("req4");
    send(500, 32'd0, 1'b1);
    bus.en = 1'b0;
    tick();
    chk("en0_req",   32'(bus.burst_req), 32'd0);
    chk("en0_lvl",   32'(bus.level),     32'd500);
    bus.en = 1'b1;                     // from IDLE a new request appears at once
    tick();
    chk("en0_idle",  32'(bus.burst_req), 32'd1);
    bus.en = 1'b0;
    tick();
    chk("en0_req2",  32'(bus.burst_req), 32'd0);
    drain_all("drain500", 600);

    // Reset mid-CAPTURE with data waiting.
    bus.en = 1'b1;
    wait_req("req5");
    send(100, 32'h1000, 1'b0);
    chk("pre_rst_vld", 32'(bus.vec_vld), 32'd1);
    bus.rdbstdrdy = 1'b1; bus.dq = 32'h1064;
    #3 reset = 1'b1;
    #1;
    chk_zero("arst");
    exp_q.delete();
    repeat (2) tick();
    #3 reset = 1'b0;
    tick();                            // IDLE->REQ; strobe in IDLE ignored
    chk("post_rst_lvl", 32'(bus.level),     32'd0);
    chk("post_rst_req", 32'(bus.burst_req), 32'd1);
    send(5, 32'h2000, 1'b1);
    chk("post_rst_lvl5", 32'(bus.level),    32'd5);
    bus.en = 1'b0;
    tick();
    drain_all("drain_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
